// File: rtl/route_hdr_scheduler.sv
// Purpose : arbitrates read/write response channels, looks up the route of the
//           granted source in an external routing table and presents one header.
// Latency : grant in cycle N, lut_path registered in N+1, hdr_valid from N+2.
// Backpressure: one header in flight; while hdr_ready=0 the header holds and
//           both rd_ready and wr_ready stay low.
//
// Ports:
//   clock, reset          sole clock; asynchronous active-high reset
//   rd_valid/rd_src/rd_ready   read-response header request
//   wr_valid/wr_src/wr_ready   write-response header request
//   lut_address, lut_path      registered address to / combinational path from routing table
//   hdr_valid/hdr_ready        header handshake towards the packetizer
//   hdr_path/hdr_src/hdr_chan  header contents (hdr_chan: 0 = read, 1 = write)
module route_hdr_scheduler #(
    parameter int SOURCEWD = 4,
    parameter int PATHWD   = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rd_valid,
    input  logic [SOURCEWD-1:0] rd_src,
    output logic                rd_ready,
    input  logic                wr_valid,
    input  logic [SOURCEWD-1:0] wr_src,
    output logic                wr_ready,
    output logic [SOURCEWD-1:0] lut_address,
    input  logic [PATHWD-1:0]   lut_path,
    output logic                hdr_valid,
    input  logic                hdr_ready,
    output logic [PATHWD-1:0]   hdr_path,
    output logic [SOURCEWD-1:0] hdr_src,
    output logic                hdr_chan
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [SOURCEWD-1:0] src_q;
    logic [PATHWD-1:0]   path_q;
    logic                chan_q;
    logic                last_q;   // channel of the most recent grant (1 = write)
    logic                grant_rd;
    logic                grant_wr;

    // Next state and grant decode. The grant is gated by reset so that the
    // ready outputs drop immediately when reset is asserted, even though the
    // state register has already been forced to IDLE.
    always_comb begin
        state_d  = state_q;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    // On a tie the read wins only if the write was granted last.
                    grant_rd = rd_valid && (!wr_valid || last_q);
                    grant_wr = wr_valid && !grant_rd;
                end
                if (grant_rd || grant_wr) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                state_d = SEND;
            end
            SEND: begin
                if (hdr_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            path_q  <= '0;
            chan_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (grant_rd || grant_wr) begin
                src_q  <= grant_wr ? wr_src : rd_src;
                chan_q <= grant_wr;
                last_q <= grant_wr;
            end
            // The table sees src_q during LOOKUP; capture its answer once.
            if (state_q == LOOKUP) begin
                path_q <= lut_path;
            end
        end
    end

    assign rd_ready    = grant_rd;
    assign wr_ready    = grant_wr;
    assign lut_address = src_q;
    assign hdr_valid   = (state_q == SEND);
    assign hdr_path    = path_q;
    assign hdr_src     = src_q;
    assign hdr_chan    = chan_q;

endmodule
